// File: rtl/complex_accum.sv
// Complex block accumulator: sums blk_len complex products, rounds half-up, shifts, saturates,
// and offers the result on a valid/ready port backed by a single holding register.
module complex_accum #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH = 48,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_real,
  input  logic [IN_WIDTH-1:0]  in_imag,
  input  logic                 in_valid,
  input  logic [LEN_WIDTH-1:0] blk_len,
  input  logic                 clr,
  output logic [OUT_WIDTH-1:0] out_real,
  output logic [OUT_WIDTH-1:0] out_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  localparam logic [ACC_WIDTH:0] Half = (ACC_WIDTH+1)'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_WIDTH:0] OutMax = (ACC_WIDTH+1)'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] OutMin = -OutMax - 1;

  state_e                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [ACC_WIDTH-1:0]   sum_re_q, sum_re_d, sum_im_q, sum_im_d;
  logic                          sum_vld_q, sum_vld_d;
  logic [LEN_WIDTH-1:0]          cnt_q, cnt_d, len_q, len_d;
  logic [OUT_WIDTH-1:0]          out_re_q, out_re_d, out_im_q, out_im_d;
  logic                          out_vld_q, out_vld_d, sat_q, sat_d, ovr_q, ovr_d;

  logic signed [ACC_WIDTH-1:0]   in_re_ext, in_im_ext, add_re, add_im;
  logic [LEN_WIDTH-1:0]          len_eff, cnt_inc;
  logic [OUT_WIDTH:0]            rs_re, rs_im;

  // Returns {clipped, value}: (s + 2^(SHIFT-1)) >>> SHIFT saturated to OUT_WIDTH.
  function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [ACC_WIDTH-1:0] s);
    logic signed [ACC_WIDTH:0] t;
    t = $signed({s[ACC_WIDTH-1], s}) + $signed(Half);
    t = t >>> SHIFT;
    if (t > OutMax) begin
      round_sat = {1'b1, OutMax[OUT_WIDTH-1:0]};
    end else if (t < OutMin) begin
      round_sat = {1'b1, OutMin[OUT_WIDTH-1:0]};
    end else begin
      round_sat = {1'b0, t[OUT_WIDTH-1:0]};
    end
  endfunction

  assign in_re_ext = ACC_WIDTH'($signed(in_real));
  assign in_im_ext = ACC_WIDTH'($signed(in_imag));
  assign add_re    = acc_re_q + in_re_ext;
  assign add_im    = acc_im_q + in_im_ext;
  assign len_eff   = (blk_len == '0) ? LEN_WIDTH'(1) : blk_len;
  assign cnt_inc   = cnt_q + LEN_WIDTH'(1);
  assign rs_re     = round_sat(sum_re_q);
  assign rs_im     = round_sat(sum_im_q);

  always_comb begin
    state_d   = state_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    sum_re_d  = sum_re_q;
    sum_im_d  = sum_im_q;
    sum_vld_d = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StIdle: begin
          acc_re_d = in_re_ext;
          acc_im_d = in_im_ext;
          len_d    = len_eff;
          if (len_eff == LEN_WIDTH'(1)) begin
            sum_re_d  = in_re_ext;
            sum_im_d  = in_im_ext;
            sum_vld_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d   = LEN_WIDTH'(1);
            state_d = StAccum;
          end
        end
        StAccum: begin
          acc_re_d = add_re;
          acc_im_d = add_im;
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) begin
            sum_re_d  = add_re;
            sum_im_d  = add_im;
            sum_vld_d = 1'b1;
            cnt_d     = '0;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A fresh result always loads; a pending unaccepted result is then lost and flagged.
  always_comb begin
    out_re_d  = out_re_q;
    out_im_d  = out_im_q;
    out_vld_d = out_vld_q;
    sat_d     = sat_q;
    ovr_d     = ovr_q;
    if (sum_vld_q) begin
      out_re_d  = rs_re[OUT_WIDTH-1:0];
      out_im_d  = rs_im[OUT_WIDTH-1:0];
      out_vld_d = 1'b1;
      sat_d     = sat_q | rs_re[OUT_WIDTH] | rs_im[OUT_WIDTH];
      ovr_d     = ovr_q | (out_vld_q & ~out_ready);
    end else if (out_vld_q && out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q   <= StIdle;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      sum_re_q  <= '0;
      sum_im_q  <= '0;
      sum_vld_q <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      out_vld_q <= 1'b0;
      sat_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sum_re_q  <= sum_re_d;
      sum_im_q  <= sum_im_d;
      sum_vld_q <= sum_vld_d;
      out_re_q  <= out_re_d;
      out_im_q  <= out_im_d;
      out_vld_q <= out_vld_d;
      sat_q     <= sat_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_real  = out_re_q;
  assign out_imag  = out_im_q;
  assign out_valid = out_vld_q;
  assign sat       = sat_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q == StAccum);

endmodule

// File: doc/complex_accum.md
Name: complex_accum

Overview:
- Downstream consumer of the pipelined complex multiplier.
- Accumulates a programmable-length block of full-precision complex products (in_valid strobes).
- Rounds and scales the block sum, saturates it to OUT_WIDTH, and presents it on a valid/ready output with a one-entry holding register.
- Serves as the complex dot-product / correlator back end.

Parameters:
IN_WIDTH, 32, signed width of each input component (multiplier output width)
ACC_WIDTH, 48, signed accumulator width; must be at least IN_WIDTH+LEN_WIDTH
LEN_WIDTH, 16, width of block-length input
OUT_WIDTH, 16, signed width of each output component
SHIFT, 15, arithmetic right shift applied to the sum before saturation; must be at least 1

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_real  input  IN_WIDTH  signed product, real part
in_imag  input  IN_WIDTH  signed product, imaginary part
in_valid  input  1  sample strobe; no backpressure
blk_len  input  LEN_WIDTH  samples per block, sampled on the first sample of each block; 0 treated as 1
clr  input  1  synchronous clear of block state and flags
out_real  output  OUT_WIDTH  rounded, saturated sum, real part
out_imag  output  OUT_WIDTH  rounded, saturated sum, imaginary part
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sat  output  1  sticky: any output component saturated
overrun  output  1  sticky: unaccepted result overwritten
busy  output  1  high while a block is partially accumulated

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, rst_n, sampled on rising clk.
- Reset (rst_n=0 at an edge):
  - accumulators, count, state, out_real, out_imag, out_valid, sat, overrun and busy all go to 0.
  - Reset mid-block discards the partial sum.
- States:
  - IDLE: count=0, busy=0.
  - ACCUM: busy=1.
- IDLE with in_valid:
  - acc <= sample, len_q <= max(blk_len,1), count <= 1.
  - If len_q==1 the block completes immediately. Otherwise go to ACCUM.
- ACCUM with in_valid:
  - acc <= acc + sample, count <= count+1.
  - When the new count equals len_q the block completes.
- Block completion:
  - The final sum is latched into the sum register on the completing edge and the FSM returns to IDLE.
  - A sample on the next edge starts a new block with no bubble.
- No in_valid: state, acc and count hold.
- Arithmetic:
  - Inputs are sign-extended to ACC_WIDTH. The accumulator wraps modulo 2^ACC_WIDTH; sizing is the integrator's responsibility.
  - Each component: r = (sum + 2^(SHIFT-1)) >>> SHIFT, which is round-half-up (toward +inf).
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. If either component clips, sat <= 1.
- Output latency:
  - The rounded, saturated result is written to out_real/out_imag one edge after the completing edge, and out_valid <= 1 on that edge.
  - So out_valid is visible 2 edges after the final sample is clocked in.
- Output handshake:
  - Transfer occurs on an edge with out_valid && out_ready. out_valid drops on that edge unless a new result loads on the same edge.
  - out_real/out_imag/out_valid hold stable while out_valid && !out_ready.
- Simultaneous new result and pending output:
  - If out_ready=1 on that edge: old result transfers, new one loads, out_valid stays 1, no overrun.
  - If out_ready=0: new result overwrites and overrun <= 1.
- clr (when rst_n=1):
  - Same effect as reset on all state and outputs. A sample in the same cycle is dropped.
  - clr has priority over in_valid, block completion and handshake.
- sat and overrun clear only on reset or clr.
- blk_len changes mid-block have no effect until the next block start.

Test Plan:
- Exact rounding: blk_len=4, four samples (32768,-32768), out_ready=1 -> one result (4,-4), out_valid high exactly 1 cycle, 2 edges after 4th sample; sat=0.
- Saturation: blk_len=1, sample (2^31-1, -2^31) -> result (32767,-32768), sat=1 and remains 1 after the next unsaturated block.
- Back-to-back blocks with gaps: blk_len=3, samples 1..6 as (65536·k, 0) with idle cycles interleaved -> results (12,0) then (30,0); busy high only between the first and last sample of each block.
- Backpressure/overrun: blk_len=1, out_ready=0, samples (32768,0) then (65536,0) -> out holds (1,0) then (2,0), overrun=1. Repeat with out_ready=1 on the overlap edge -> (1,0) transferred, (2,0) loaded, overrun=0.
- blk_len edge cases: blk_len=0 -> each sample is its own block. blk_len changed 4->2 after the 2nd sample -> current block still closes after 4 samples, next block after 2.
- Clear/reset mid-block: blk_len=4, two samples, then clr together with a third sample (or rst_n=0) -> busy=0, out_valid=0, flags 0; the next 4 samples produce a result from those 4 only.
